wtch_datapath_cal: RTL and testbench
====================================

// Module: wtch_datapath_cal
// PURPOSE
//   Parametrised time-of-day datapath for the dual-watch design: prescaler + cascaded cs/sec/min/hour counters.
//   Successor to the fixed watch datapath. Adds selectable-field calibration with optional carry/borrow,
//   synchronous time load with range saturation, deferred-tick arbitration, a seconds strobe and an HH:MM alarm.
//   Sits between the control FSM (run/sel/up/dn/load from debounced buttons and UART commands) and the FND/UART formatters.
// PARAMETERS
//   DIV_TICK   1_000_000  clk cycles per centisecond tick; SIM builds use 10; legal range >=2
//   CS_MAX     100        sub-second modulus; cs counts 0..CS_MAX-1; legal range 2..128
//   HOUR_INIT  12         hour value after reset and after clr; legal range 0..23
//   CAL_CARRY  1          1: calibration steps carry/borrow into higher fields; 0: selected field wraps alone
// PORTS
//   clk        in   1  system clock, 100 MHz
//   rst_n      in   1  asynchronous reset, active low
//   run        in   1  1 = prescaler advances; 0 = time frozen (calibration still allowed)
//   clr        in   1  sync clear to 00:00 at HOUR_INIT (cs=sec=min=0, hour=HOUR_INIT), prescaler 0
//   load       in   1  1-cycle pulse: take ld_hour/ld_min/ld_sec, set cs=0
//   ld_hour    in   5  load value, hour
//   ld_min     in   6  load value, min
//   ld_sec     in   6  load value, sec
//   sel        in   2  calibration field: 0=cs, 1=sec, 2=min, 3=hour
//   up         in   1  1-cycle pulse: selected field +1
//   dn         in   1  1-cycle pulse: selected field -1
//   alarm_en   in   1  enables alarm_hit
//   alarm_hour in   5  alarm hour, 0..23
//   alarm_min  in   6  alarm minute, 0..59
//   cs         out  7  centiseconds, 0..CS_MAX-1
//   sec        out  6  seconds, 0..59
//   min        out  6  minutes, 0..59
//   hour       out  5  hours, 0..23
//   tick_sec   out  1  1-cycle pulse when sec advances through the cs carry
//   alarm_hit  out  1  1-cycle pulse on reaching alarm_hour:alarm_min:00.00 through a tick
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     cs=0, sec=0, min=0, hour=HOUR_INIT; tick_sec=0, alarm_hit=0; prescaler=0, pending=0. Release resumes at the next clk edge.
//   Prescaler
//     Counts 0..DIV_TICK-1 while run=1. Internal tick fires when count==DIV_TICK-1; count returns to 0.
//     run=0 holds the count. clr and load zero it.
//   Per-cycle priority: clr > load > calibration > tick
//     clr: clears time, pending, prescaler. Pulses stay 0.
//     load: ld values saturate (ld_hour>23 -> 23; ld_min/ld_sec>59 -> 59). cs=0; pending cleared.
//     calibration: up^dn=1 steps the sel field. up&dn=1 is ignored (no step).
//       CAL_CARRY=1: full carry/borrow chain applies.
//         Borrow below 00:00:00.00 wraps to 23:59:59.(CS_MAX-1).
//         Carry above 23:59:59.(CS_MAX-1) wraps to 00:00:00.00.
//       CAL_CARRY=0: only the selected field changes (sec 59+1 -> 0, min untouched; hour 0-1 -> 23).
//     tick: cs+1; at CS_MAX-1 -> 0 with carry to sec. sec/min 59 -> 0 with carry. hour 23 -> 0.
//   Tick colliding with calibration
//     Tick is deferred, not lost: pending=1, applied on the next cycle with no calibration step.
//     Pending holds at most one tick; DIV_TICK>=2 guarantees no overflow.
//   Latency
//     All outputs registered. A field change is visible the cycle after the causing edge (tick, load, up/dn).
//   Pulses
//     tick_sec=1 in the same cycle sec shows its tick-advanced value. Never set by calibration or load.
//     alarm_hit=1 in the same cycle the outputs first show alarm_hour:alarm_min:00.00, only if that state
//     was reached by a tick (including a deferred tick) and alarm_en=1. Load/calibration onto the alarm time: no pulse.
// TESTING  (DIV_TICK=10, CS_MAX=100, HOUR_INIT=12, CAL_CARRY=1 unless stated)
//   T1 rst_n low then high, run=1 for 1000 clk
//      -> cs=0 until the first tick, then cs=100 reached as sec=1/cs=0; tick_sec exactly once; hour=12.
//   T2 load 23:59:59 with cs set to 99 by calibration, then run to the next tick
//      -> 00:00:00.00; tick_sec pulse; no alarm (alarm_en=0).
//   T3 time 00:00:00.00, sel=0, dn pulse -> 23:59:59.99.
//      Repeat with CAL_CARRY=0, sel=1 at sec=59, up -> sec=0, min unchanged.
//   T4 up pulse on the exact cycle of an internal tick, sel=2, from 10:05:30.40
//      -> next cycle 10:06:30.40, following cycle 10:06:30.41.
//   T5 alarm 07:30, alarm_en=1, load 07:29:59, calibrate cs to 99, run one tick
//      -> 07:30:00.00 with alarm_hit=1 for one cycle. Load 07:30:00 directly -> alarm_hit stays 0.
//   T6 load ld_hour=31, ld_min=63, ld_sec=60 -> 23:59:59.00.
//      up&dn asserted together -> no change. rst_n low mid-count -> 12:00:00.00 immediately.

Source files
------------

// File: rtl/wtch_datapath_cal.sv
// wtch_datapath_cal: prescaled cs/sec/min/hour time-of-day counters with calibration,
// saturating load, deferred-tick arbitration, seconds strobe and HH:MM alarm.
module wtch_datapath_cal #(
    parameter int DIV_TICK  = 1_000_000,
    parameter int CS_MAX    = 100,
    parameter int HOUR_INIT = 12,
    parameter int CAL_CARRY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic       load,
    input  logic [4:0] ld_hour,
    input  logic [5:0] ld_min,
    input  logic [5:0] ld_sec,
    input  logic [1:0] sel,
    input  logic       up,
    input  logic       dn,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    output logic [6:0] cs,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       tick_sec,
    output logic       alarm_hit
);
    localparam int PW = $clog2(DIV_TICK);
    localparam logic [PW-1:0] PRE_TOP = PW'(DIV_TICK - 1);
    localparam logic [6:0] CS_TOP = 7'(CS_MAX - 1);
    localparam logic [4:0] H_INIT = 5'(HOUR_INIT);

    logic [PW-1:0] pre;
    logic          pending;
    logic          tick_int, cal, do_tick, dir_up, chain;
    logic [1:0]    lvl;
    logic          hit_cs, hit_sec, hit_min, hit_hour;
    logic          wrap_cs, wrap_sec, wrap_min, wrap_hour;
    logic [6:0]    cs_n;
    logic [5:0]    sec_n, min_n;
    logic [4:0]    hour_n;
    logic          alarm_match;

    // A tick is just an up-step at the cs level that always carries, so tick and
    // calibration share one carry/borrow chain.
    always_comb begin
        tick_int    = run && (pre == PRE_TOP);
        cal         = up ^ dn;
        do_tick     = !cal && (tick_int || pending);
        dir_up      = do_tick || up;
        lvl         = do_tick ? 2'd0 : sel;
        chain       = do_tick || (CAL_CARRY != 0);
        wrap_cs     = dir_up ? (cs == CS_TOP) : (cs == 7'd0);
        wrap_sec    = dir_up ? (sec == 6'd59) : (sec == 6'd0);
        wrap_min    = dir_up ? (min == 6'd59) : (min == 6'd0);
        wrap_hour   = dir_up ? (hour == 5'd23) : (hour == 5'd0);
        hit_cs      = lvl == 2'd0;
        hit_sec     = (lvl == 2'd1) || (hit_cs && wrap_cs && chain);
        hit_min     = (lvl == 2'd2) || (hit_sec && wrap_sec && chain);
        hit_hour    = (lvl == 2'd3) || (hit_min && wrap_min && chain);
        cs_n        = !hit_cs ? cs : dir_up ? (wrap_cs ? 7'd0 : cs + 7'd1) : (wrap_cs ? CS_TOP : cs - 7'd1);
        sec_n       = !hit_sec ? sec : dir_up ? (wrap_sec ? 6'd0 : sec + 6'd1) : (wrap_sec ? 6'd59 : sec - 6'd1);
        min_n       = !hit_min ? min : dir_up ? (wrap_min ? 6'd0 : min + 6'd1) : (wrap_min ? 6'd59 : min - 6'd1);
        hour_n      = !hit_hour ? hour : dir_up ? (wrap_hour ? 5'd0 : hour + 5'd1) : (wrap_hour ? 5'd23 : hour - 5'd1);
        alarm_match = (cs_n == 7'd0) && (sec_n == 6'd0) && (min_n == alarm_min) && (hour_n == alarm_hour);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre       <= '0;
            pending   <= 1'b0;
            cs        <= 7'd0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= H_INIT;
            tick_sec  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            tick_sec  <= 1'b0;
            alarm_hit <= 1'b0;
            if (clr) begin
                pre     <= '0;
                pending <= 1'b0;
                cs      <= 7'd0;
                sec     <= 6'd0;
                min     <= 6'd0;
                hour    <= H_INIT;
            end else if (load) begin
                pre     <= '0;
                pending <= 1'b0;
                cs      <= 7'd0;
                sec     <= (ld_sec > 6'd59) ? 6'd59 : ld_sec;
                min     <= (ld_min > 6'd59) ? 6'd59 : ld_min;
                hour    <= (ld_hour > 5'd23) ? 5'd23 : ld_hour;
            end else begin
                pre     <= tick_int ? '0 : run ? pre + PW'(1) : pre;
                pending <= cal && (tick_int || pending);
                if (cal || do_tick) begin
                    cs   <= cs_n;
                    sec  <= sec_n;
                    min  <= min_n;
                    hour <= hour_n;
                end
                tick_sec  <= do_tick && wrap_cs;
                alarm_hit <= do_tick && alarm_en && alarm_match;
            end
        end
    end
endmodule

// File: tb/tb_wtch_datapath_cal.sv
// tb_wtch_datapath_cal: scoreboard bench; a centisecond-count reference model predicts
// every cycle of a carrying and a non-carrying instance driven by the same stimulus.
module tb_wtch_datapath_cal;
    localparam int DIV = 10;
    localparam int CSM = 100;
    localparam int HI  = 12;
    localparam int DAY = 24 * 3600 * CSM;

    typedef struct packed {
        logic [6:0] cs;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic       ts;
        logic       ah;
    } obs_t;

    logic clk = 0, rst_n = 0, run = 0, clr = 0, load = 0, up = 0, dn = 0, alarm_en = 0;
    logic [4:0] ld_hour = 0, alarm_hour = 0;
    logic [5:0] ld_min = 0, ld_sec = 0, alarm_min = 0;
    logic [1:0] sel = 0;
    logic [6:0] cs_a, cs_b;
    logic [5:0] sec_a, sec_b, min_a, min_b;
    logic [4:0] hour_a, hour_b;
    logic ts_a, ts_b, ah_a, ah_b;

    logic n_rst_n = 0, n_run = 0, n_clr = 0, n_load = 0, n_up = 0, n_dn = 0, n_aen = 0;
    logic [4:0] n_ldh = 0, n_ah = 0;
    logic [5:0] n_ldm = 0, n_lds = 0, n_am = 0;
    logic [1:0] n_sel = 0;

    obs_t qa[$], qb[$];
    int ta = HI * 3600 * CSM, tb2 = HI * 3600 * CSM, pre = 0;
    bit pend = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    wtch_datapath_cal #(.DIV_TICK(DIV), .CS_MAX(CSM), .HOUR_INIT(HI), .CAL_CARRY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .load(load),
        .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec), .sel(sel), .up(up), .dn(dn),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .cs(cs_a), .sec(sec_a), .min(min_a), .hour(hour_a), .tick_sec(ts_a), .alarm_hit(ah_a));

    wtch_datapath_cal #(.DIV_TICK(DIV), .CS_MAX(CSM), .HOUR_INIT(HI), .CAL_CARRY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .load(load),
        .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec), .sel(sel), .up(up), .dn(dn),
        .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .cs(cs_b), .sec(sec_b), .min(min_b), .hour(hour_b), .tick_sec(ts_b), .alarm_hit(ah_b));

    function automatic obs_t mk(int t, bit ts, bit ah);
        obs_t o;
        o.cs   = 7'(t % CSM);
        o.sec  = 6'((t / CSM) % 60);
        o.min  = 6'((t / (CSM * 60)) % 60);
        o.hour = 5'(t / (CSM * 3600));
        o.ts   = ts;
        o.ah   = ah;
        return o;
    endfunction

    // Time is one count of centiseconds since midnight; a step at a field is +/- its weight.
    task automatic model();
        int w[4] = '{1, CSM, CSM * 60, CSM * 3600};
        int md[4] = '{CSM, 60, 60, 24};
        int f[4];
        int al;
        bit tk, cl, dt, tsa = 0, aha = 0, tsb = 0, ahb = 0;
        al = (int'(alarm_hour) * 3600 + int'(alarm_min) * 60) * CSM;
        if (!rst_n || clr) begin
            ta = HI * 3600 * CSM; tb2 = ta; pre = 0; pend = 0;
        end else if (load) begin
            ta = ((ld_hour > 23 ? 23 : int'(ld_hour)) * 3600 + (ld_min > 59 ? 59 : int'(ld_min)) * 60
                  + (ld_sec > 59 ? 59 : int'(ld_sec))) * CSM;
            tb2 = ta; pre = 0; pend = 0;
        end else begin
            tk = run && pre == DIV - 1;
            pre = tk ? 0 : run ? pre + 1 : pre;
            cl = up ^ dn;
            dt = !cl && (tk || pend);
            pend = cl && (tk || pend);
            if (cl) begin
                ta = (ta + (up ? w[sel] : DAY - w[sel])) % DAY;
                for (int k = 0; k < 4; k++) f[k] = (tb2 / w[k]) % md[k];
                f[sel] = (f[sel] + (up ? 1 : md[sel] - 1)) % md[sel];
                tb2 = 0;
                for (int k = 0; k < 4; k++) tb2 += f[k] * w[k];
            end
            if (dt) begin
                ta = (ta + 1) % DAY;
                tb2 = (tb2 + 1) % DAY;
                tsa = ta % CSM == 0;
                tsb = tb2 % CSM == 0;
                aha = alarm_en && ta == al;
                ahb = alarm_en && tb2 == al;
            end
        end
        qa.push_back(mk(ta, tsa, aha));
        qb.push_back(mk(tb2, tsb, ahb));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        rst_n = n_rst_n; run = n_run; clr = n_clr; load = n_load; up = n_up; dn = n_dn; sel = n_sel;
        ld_hour = n_ldh; ld_min = n_ldm; ld_sec = n_lds;
        alarm_en = n_aen; alarm_hour = n_ah; alarm_min = n_am;
        model();
        n_clr = 0; n_load = 0; n_up = 0; n_dn = 0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        n_ldh = 5'(h); n_ldm = 6'(m); n_lds = 6'(s); n_load = 1;
        step();
    endtask

    task automatic cal_cs(input int n);
        repeat (n) begin n_sel = 0; n_up = 1; step(); end
    endtask

    initial begin
        obs_t ea, eb, oa, ob;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                oa = {cs_a, sec_a, min_a, hour_a, ts_a, ah_a};
                ob = {cs_b, sec_b, min_b, hour_b, ts_b, ah_b};
                total += 2;
                if (oa !== ea) begin
                    bad++;
                    $display("FAIL carry @%0t: got %0d:%0d:%0d.%0d ts=%b ah=%b want %0d:%0d:%0d.%0d ts=%b ah=%b", $time,
                             oa.hour, oa.min, oa.sec, oa.cs, oa.ts, oa.ah, ea.hour, ea.min, ea.sec, ea.cs, ea.ts, ea.ah);
                end
                if (ob !== eb) begin
                    bad++;
                    $display("FAIL nocarry @%0t: got %0d:%0d:%0d.%0d ts=%b ah=%b want %0d:%0d:%0d.%0d ts=%b ah=%b", $time,
                             ob.hour, ob.min, ob.sec, ob.cs, ob.ts, ob.ah, eb.hour, eb.min, eb.sec, eb.cs, eb.ts, eb.ah);
                end
            end
        end
    end

    initial begin
        // reset then free run
        repeat (3) step();
        n_rst_n = 1; n_run = 1;
        repeat (1000) step();
        // rollover through midnight
        n_run = 0; do_load(23, 59, 59); cal_cs(99);
        n_run = 1; repeat (12) step();
        // borrow below midnight, and single-field wrap
        n_run = 0; do_load(0, 0, 0);
        n_sel = 0; n_dn = 1; step();
        do_load(0, 0, 59);
        n_sel = 1; n_up = 1; step();
        // calibration colliding with a tick
        do_load(10, 5, 30); cal_cs(40);
        n_run = 1; repeat (9) step();
        n_sel = 2; n_up = 1; step();
        repeat (3) step();
        // alarm via tick, then no alarm via load
        n_run = 0; n_aen = 1; n_ah = 7; n_am = 30;
        do_load(7, 29, 59); cal_cs(99);
        n_run = 1; repeat (12) step();
        n_run = 0; do_load(7, 30, 0); step();
        // saturation, up&dn together, reset mid-count
        do_load(31, 63, 60);
        n_sel = 2; n_up = 1; n_dn = 1; step();
        n_run = 1; repeat (5) step();
        n_rst_n = 0; step();
        n_rst_n = 1; repeat (3) step();
        // randomized traffic
        repeat (4000) begin
            n_rst_n = $urandom_range(0, 499) != 0;
            n_run   = $urandom_range(0, 9) != 0;
            n_clr   = $urandom_range(0, 299) == 0;
            n_load  = $urandom_range(0, 59) == 0;
            n_ldh   = 5'($urandom_range(0, 31));
            n_ldm   = 6'($urandom_range(0, 63));
            n_lds   = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 63));
            n_up    = $urandom_range(0, 5) == 0;
            n_dn    = $urandom_range(0, 5) == 0;
            n_sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                n_aen = 1;
                n_ah = 5'(ta / (CSM * 3600));
                n_am = 6'(((ta / (CSM * 60)) + 1) % 60);
            end
            step();
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
